// File: rtl/counter_checker_pkg.sv
// Shared types and default parameters for the counter_checker block.
package counter_checker_pkg;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int W_DEF        = 9;
    localparam int LOCK_CNT_DEF = 4;
    localparam int ERR_W_DEF    = 8;

endpackage

// File: rtl/counter_checker_if.sv
// Counter stream input and checker status outputs bundled as one bus.
interface counter_checker_if #(
    parameter int W     = 9,
    parameter int ERR_W = 8
);
    logic [W-1:0]     data_in;
    logic             valid_in;
    logic             locked;
    logic             error;
    logic [ERR_W-1:0] err_count;
    logic [W-1:0]     expected;

    modport master (
        output data_in, valid_in,
        input  locked, error, err_count, expected
    );

    modport slave (
        input  data_in, valid_in,
        output locked, error, err_count, expected
    );
endinterface

// File: rtl/counter_checker_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-high reset.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) count_d = count_q + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/counter_checker.sv
// Checks that sampled counter values step by exactly +1 (mod 2^W).
// Optional: define COUNTER_CHECKER_RESYNC_EN to drop back to SEARCH on a locked mismatch.
module counter_checker
    import counter_checker_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int ERR_W    = ERR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    counter_checker_if.slave  bus
);
    localparam int              GR_W   = $clog2(LOCK_CNT + 1);
    localparam logic [GR_W-1:0] GR_MAX = GR_W'(LOCK_CNT);

    state_e          state_q, state_d;
    logic            have_q, have_d;
    logic [W-1:0]    prev_q, prev_d;
    logic [W-1:0]    exp_q, exp_d;
    logic [GR_W-1:0] gr_q, gr_d;
    logic [GR_W-1:0] gr_inc;
    logic            err_q, err_d;
    logic            inc_err;
    logic [W-1:0]    prev_inc;
    logic            match;

    // W-bit add so the all-ones -> zero wrap counts as a match.
    assign prev_inc = prev_q + W'(1);
    assign match    = (bus.data_in == prev_inc);
    assign gr_inc   = (gr_q == GR_MAX) ? GR_MAX : gr_q + GR_W'(1);

    always_comb begin
        state_d = state_q;
        have_d  = have_q;
        prev_d  = prev_q;
        gr_d    = gr_q;
        err_d   = 1'b0;
        inc_err = 1'b0;
        if (bus.valid_in) begin
            if (!have_q) begin
                have_d = 1'b1;
                prev_d = bus.data_in;
                gr_d   = '0;
            end else if (state_q == SEARCH) begin
                prev_d = bus.data_in;
                if (match) begin
                    gr_d = gr_inc;
                    if (gr_inc == GR_MAX) state_d = LOCKED;
                end else begin
                    gr_d = '0;
                end
            end else if (match) begin
                prev_d = bus.data_in;
            end else begin
                err_d   = 1'b1;
                inc_err = 1'b1;
`ifdef COUNTER_CHECKER_RESYNC_EN
                state_d = SEARCH;
                prev_d  = bus.data_in;
                gr_d    = '0;
`else
                // Flywheel on our own sequence so every off-sequence sample is an error.
                prev_d  = prev_inc;
`endif
            end
        end
        exp_d = have_d ? prev_d + W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEARCH;
            have_q  <= 1'b0;
            prev_q  <= '0;
            gr_q    <= '0;
            err_q   <= 1'b0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            have_q  <= have_d;
            prev_q  <= prev_d;
            gr_q    <= gr_d;
            err_q   <= err_d;
            exp_q   <= exp_d;
        end
    end

    sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_err),
        .count (bus.err_count)
    );

    assign bus.locked   = (state_q == LOCKED);
    assign bus.error    = err_q;
    assign bus.expected = exp_q;
endmodule

// File: tb/tb_counter_checker.sv
// Directed bench: two checkers (ERR_W=8 and ERR_W=2) on one stream, scored against a behavioural model.
module tb_counter_checker;

    logic       clk = 1'b0;
    logic       r   = 1'b1;
    logic       v   = 1'b0;
    logic [8:0] d   = '0;

    always #5 clk = ~clk;

    counter_checker_if #(.W(9), .ERR_W(8)) bus_a ();
    counter_checker_if #(.W(9), .ERR_W(2)) bus_b ();

    assign bus_a.data_in  = d;
    assign bus_a.valid_in = v;
    assign bus_b.data_in  = d;
    assign bus_b.valid_in = v;

    counter_checker #(.W(9), .LOCK_CNT(4), .ERR_W(8)) dut_a (.clk(clk), .rst(r), .bus(bus_a));
    counter_checker #(.W(9), .LOCK_CNT(4), .ERR_W(2)) dut_b (.clk(clk), .rst(r), .bus(bus_b));

    typedef struct {
        logic       locked;
        logic       error;
        logic [7:0] ec8;
        logic [1:0] ec2;
        logic [8:0] expv;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;
    int pulses = 0;

    // reference model state
    logic       m_have = 1'b0;
    logic       m_locked = 1'b0;
    logic       m_err = 1'b0;
    logic [8:0] m_prev = '0;
    int         m_gr = 0;
    int         m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exv);
        n_chk++;
        assert (obs === exv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exv);
        end
    endtask

    task automatic model(input logic rr, input logic vv, input logic [8:0] dd);
        logic [8:0] nxt;
        nxt = m_prev + 9'd1;
        if (rr) begin
            m_have = 0; m_locked = 0; m_err = 0; m_prev = '0; m_gr = 0; m_cnt = 0;
        end else if (!vv) begin
            m_err = 0;
        end else if (!m_have) begin
            m_have = 1; m_prev = dd; m_gr = 0; m_err = 0;
        end else begin
            m_err = 0;
            if (!m_locked) begin
                m_gr = (dd == nxt) ? ((m_gr < 4) ? m_gr + 1 : 4) : 0;
                if (m_gr == 4) m_locked = 1;
                m_prev = dd;
            end else if (dd == nxt) begin
                m_prev = dd;
            end else begin
                m_err = 1;
                m_cnt++;
`ifdef COUNTER_CHECKER_RESYNC_EN
                m_locked = 0; m_gr = 0; m_prev = dd;
`else
                m_prev = nxt;
`endif
            end
        end
    endtask

    task automatic step(input logic rr, input logic vv, input logic [8:0] dd);
        exp_t e;
        @(negedge clk);
        r = rr; v = vv; d = dd;
        model(rr, vv, dd);
        e.locked = m_locked;
        e.error  = m_err;
        e.ec8    = (m_cnt > 255) ? 8'hff : 8'(m_cnt);
        e.ec2    = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
        e.expv   = m_have ? m_prev + 9'd1 : 9'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (bus_a.error === 1'b1) pulses++;
        chk("sb_locked",   bus_a.locked,    e.locked);
        chk("sb_error",    bus_a.error,     e.error);
        chk("sb_errcnt",   bus_a.err_count, e.ec8);
        chk("sb_expected", bus_a.expected,  e.expv);
        chk("sb_b_locked", bus_b.locked,    e.locked);
        chk("sb_b_errcnt", bus_b.err_count, e.ec2);
    endtask

    task automatic lock_seq(input logic [8:0] start);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, start + 9'(i));
    endtask

    // One locked mismatch; with resync, relock right after it.
    task automatic bad_sample(input logic [8:0] bad);
        step(1'b0, 1'b1, bad);
`ifdef COUNTER_CHECKER_RESYNC_EN
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, bad + 9'(i));
`endif
    endtask

    initial begin
        // reset state
        step(1'b1, 1'b0, 9'd0);
        chk("rst_locked", bus_a.locked, 0);
        chk("rst_error", bus_a.error, 0);
        chk("rst_errcnt", bus_a.err_count, 0);
        chk("rst_expected", bus_a.expected, 0);

        // lock on 0..4
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 9'(i));
        chk("lock_early", bus_a.locked, 0);
        step(1'b0, 1'b1, 9'd4);
        chk("lock_locked", bus_a.locked, 1);
        chk("lock_errcnt", bus_a.err_count, 0);
        chk("lock_expected", bus_a.expected, 5);

        // mismatch while locked
        step(1'b0, 1'b1, 9'd5);
        step(1'b0, 1'b1, 9'd10);
        chk("mm_error", bus_a.error, 1);
        chk("mm_errcnt", bus_a.err_count, 1);
        step(1'b0, 1'b0, 9'd0);
        chk("mm_pulse_end", bus_a.error, 0);
`ifdef COUNTER_CHECKER_RESYNC_EN
        chk("mm_unlocked", bus_a.locked, 0);
        for (int i = 11; i <= 14; i++) step(1'b0, 1'b1, 9'(i));
        chk("mm_relocked", bus_a.locked, 1);
`else
        chk("mm_still_locked", bus_a.locked, 1);
        chk("mm_flywheel", bus_a.expected, 7);
`endif

        // wrap 509..1
        step(1'b1, 1'b0, 9'd0);
        pulses = 0;
        lock_seq(9'd509);
        chk("wrap_locked", bus_a.locked, 1);
        chk("wrap_expected", bus_a.expected, 2);
        chk("wrap_no_error", pulses, 0);

        // gapped valid: 3 idle cycles between samples
        step(1'b1, 1'b0, 9'd0);
        for (int i = 0; i <= 5; i++) begin
            step(1'b0, 1'b1, 9'(i));
            if (i == 3) chk("gap_not_yet", bus_a.locked, 0);
            if (i == 4) chk("gap_locked", bus_a.locked, 1);
            for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 9'h1ff);
        end

        // reset mid-operation with err_count=2
        step(1'b1, 1'b0, 9'd0);
        lock_seq(9'd0);
        bad_sample(9'd200);
        bad_sample(9'd250);
        chk("rmid_pre_locked", bus_a.locked, 1);
        chk("rmid_pre_errcnt", bus_a.err_count, 2);
        step(1'b1, 1'b1, 9'd77);
        chk("rmid_locked", bus_a.locked, 0);
        chk("rmid_error", bus_a.error, 0);
        chk("rmid_errcnt", bus_a.err_count, 0);
        chk("rmid_expected", bus_a.expected, 0);
        step(1'b0, 1'b1, 9'd100);
        chk("rmid_first_exp", bus_a.expected, 101);
        chk("rmid_first_err", bus_a.error, 0);
        chk("rmid_first_lock", bus_a.locked, 0);

        // saturation of the 2-bit counter
        step(1'b1, 1'b0, 9'd0);
        lock_seq(9'd0);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 9'(200 + 50 * k));
            chk("sat_b_errcnt", bus_b.err_count, (k >= 2) ? 3 : k + 1);
            chk("sat_b_error", bus_b.error, 1);
`ifdef COUNTER_CHECKER_RESYNC_EN
            for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 9'(200 + 50 * k + i));
`endif
        end
        chk("sat_pulses", pulses, 5);
        chk("sat_a_errcnt", bus_a.err_count, 5);

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Consumer end of the free-running up-counter data stream. Samples a W-bit counter value on each valid strobe and checks that it is exactly the previous sample plus one, modulo 2^W.
- Reports lock status, a one-cycle error pulse and a saturating error count.
- Sits between the counter output bus and the LED/status logic, or is read back by host tooling for on-board self-test.

Parameters:
- W, 9, width of the checked counter value.
- LOCK_CNT, 4, consecutive correct increments needed to enter LOCKED (must be ≥1).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  W  counter value under check.
- valid_in  input  1  data_in is sampled on a rising clk edge only while this is high (e.g. prescaler tick).
- locked  output  1  high while in LOCKED state.
- error  output  1  one-cycle pulse on a mismatch detected while LOCKED.
- err_count  output  ERR_W  number of errors since reset; saturates at all-ones.
- expected  output  W  next value the checker expects (prev+1 mod 2^W); 0 until the first sample.

Behaviour:
- Reset (synchronous, rst high at a rising edge): state=SEARCH, have_prev=0, prev=0, good_run=0, locked=0, error=0, err_count=0, expected=0. rst overrides valid_in in the same cycle, including mid-LOCKED.
- All outputs are registered and reflect a sample in the cycle after the edge that sampled it (latency 1).
- valid_in low: all state holds; error is forced to 0 (pulse never stretches).
- First valid sample after reset:
  - prev<=data_in, have_prev<=1, good_run<=0, no error.
  - expected<=data_in+1 mod 2^W.
- Match on a valid sample: data_in == prev+1, computed in W bits so 2^W-1 -> 0 is a match.
- SEARCH state, each valid sample after the first:
  - Match: good_run++.
  - Mismatch: good_run<=0, no error pulse.
  - prev<=data_in in both cases.
  - When the incremented good_run equals LOCK_CNT, go to LOCKED; locked is high from the next cycle.
  - good_run saturates at LOCK_CNT; it is sized with $clog2(LOCK_CNT+1) bits.
- LOCKED state, each valid sample:
  - Match: prev<=data_in, stay LOCKED.
  - Mismatch: error<=1 for exactly one cycle; err_count<=err_count+1 unless it is all-ones; the next state depends on the optional feature.
- expected always equals prev+1 mod 2^W once have_prev=1.
- Back-to-back valid cycles are fully supported, including a mismatch on consecutive cycles; each produces its own error pulse.

Optional Feature:
- Macro: COUNTER_CHECKER_RESYNC_EN.
- Defined: a mismatch in LOCKED drops to SEARCH with prev<=data_in and good_run<=0. locked falls in the same cycle error rises. Relock needs LOCK_CNT fresh correct increments.
- Undefined: a mismatch in LOCKED stays LOCKED and prev<=prev+1, i.e. the checker flywheels on its own sequence. Every sample off that sequence is counted as an error.

Decomposition:
- Shared package counter_checker_pkg holds:
  - the state enum {SEARCH, LOCKED}, encoded 1 bit;
  - the default constants for W, LOCK_CNT and ERR_W.
- One sub-module, sat_counter: parameter WIDTH, inputs clk, rst, inc; output count; increments by 1 on inc and saturates at all-ones. Used for err_count.
- Match compare, good_run and the state machine stay in the top module.

Test Plan:
- Lock (W=9, LOCK_CNT=4): after reset, valid each cycle with data 0,1,2,3,4 -> locked=1 in the cycle after data 4 is sampled; err_count=0; expected=5.
- Wrap: data 509,510,511,0,1 -> locked=1, error never asserted, expected=2.
- Mismatch while locked (data ...,5 then 10):
  - -> error=1 for one cycle and err_count=1 in both builds.
  - With RESYNC: locked=0; then 11,12,13,14 -> locked=1 again.
  - Without RESYNC: locked stays 1; expected=7.
- Gapped valid: samples 0..5 with 3 idle cycles between each -> same lock timing relative to valid samples; error=0 throughout the idle cycles.
- Saturation (ERR_W=2, RESYNC undefined): lock, then 5 mismatching samples -> err_count 1,2,3,3,3; error pulses 5 times.
- Reset mid-operation: assert rst for 1 cycle while LOCKED with err_count=2 -> all outputs 0 next cycle; next sample 100 only loads prev; expected=101; no error.
